// File: rtl/bisr_pkg.sv
// Shared types for the BISR recompute-unit scheduler.
//   state_e     : scanner FSM states
//   ru_coord_t  : (row, col) coordinate of a PE bound to a recompute unit,
//                 sized for arrays up to 256x256
//   coord_of    : row-major PE index -> (row, col)
package bisr_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int COORD_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } ru_coord_t;

  function automatic ru_coord_t coord_of(input int unsigned idx, input int unsigned cols);
    ru_coord_t c;
    c.row = COORD_W'(idx / cols);
    c.col = COORD_W'(idx % cols);
    return c;
  endfunction

endpackage

// File: rtl/ru_alloc_table.sv
// NUM_RU-entry table of recompute-unit bindings.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : wipe every entry (start of a new allocation)
//   wr_en         : bind entry wr_ptr to (wr_row, wr_col) and mark it valid
//   valid         : per-entry bound flag
//   row, col      : flattened coordinates, entry k at [k*RW +: RW] / [k*CW +: CW]
module ru_alloc_table #(
  parameter int NUM_RU = 4,
  parameter int RW     = 2,
  parameter int CW     = 2,
  parameter int AW     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_ptr,
  input  logic [RW-1:0]        wr_row,
  input  logic [CW-1:0]        wr_col,
  output logic [NUM_RU-1:0]    valid,
  output logic [NUM_RU*RW-1:0] row,
  output logic [NUM_RU*CW-1:0] col
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= '0;
      row   <= '0;
      col   <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_RU; k++) begin
        if (wr_ptr == AW'(k)) begin
          valid[k]          <= 1'b1;
          row[k*RW +: RW]   <= wr_row;
          col[k*CW +: CW]   <= wr_col;
        end
      end
    end
  end

endmodule

// File: rtl/ru_fault_scheduler.sv
// Binds faulty PEs of a ROWS x COLS array to recompute units.
// A diagnosis snapshot is scanned one PE per cycle in row-major order; the
// k-th faulty PE found is bound to RU k. Faults beyond NUM_RU stay uncovered
// and raise unrepairable.
//   clk, rst      : clock, synchronous active-high reset
//   diag_start    : accepted only in IDLE; diag_mat is captured on that edge
//   diag_mat      : bit r*COLS+c, 1 = healthy, 0 = faulty
//   busy          : scan in progress
//   map_done      : one-cycle pulse, table outputs are final from this cycle
//   ru_valid/ru_row/ru_col : per-RU binding table
//   covered_mask  : faulty PEs served by an RU
//   fault_count   : all faulty PEs found (not capped)
//   unrepairable  : fault_count > NUM_RU
//   fsm_state     : scanner state, for observation
// Handshake: diag_start is a single-cycle request with no back-pressure; it is
// taken only while busy=0 and the FSM is idle, and ignored otherwise. Table
// outputs may change while busy=1 and are only meaningful from map_done on.
module ru_fault_scheduler
  import bisr_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4,
  localparam int NPE   = ROWS * COLS,
  localparam int IW    = (NPE > 1) ? $clog2(NPE) : 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int FW    = $clog2(NPE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 diag_start,
  input  logic [NPE-1:0]       diag_mat,
  output logic                 busy,
  output logic                 map_done,
  output logic [NUM_RU-1:0]    ru_valid,
  output logic [NUM_RU*RW-1:0] ru_row,
  output logic [NUM_RU*CW-1:0] ru_col,
  output logic [NPE-1:0]       covered_mask,
  output logic [FW-1:0]        fault_count,
  output logic                 unrepairable,
  output state_e               fsm_state
);

  localparam int AW = $clog2(NUM_RU + 1);

  if (NUM_RU < 1) begin : g_bad_num_ru
    $error("ru_fault_scheduler: NUM_RU must be at least 1");
  end
  if (ROWS > 256 || COLS > 256) begin : g_bad_dims
    $error("ru_fault_scheduler: ROWS/COLS exceed coordinate width");
  end

  state_e         state, state_nxt;
  logic [NPE-1:0] snap;
  logic [IW-1:0]  idx;
  logic [AW-1:0]  alloc;

  logic start_ok, is_fault, can_alloc, last;

  assign start_ok  = (state == S_IDLE) && diag_start;
  assign is_fault  = (state == S_SCAN) && !snap[idx];
  assign can_alloc = alloc < AW'(NUM_RU);
  assign last      = idx == IW'(NPE - 1);
  assign busy      = state == S_SCAN;
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (diag_start) state_nxt = S_SCAN;
      S_SCAN:  if (last)       state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // map_done is registered from the DONE state, so the pulse appears in the
  // cycle after DONE while the FSM is already back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      snap         <= '0;
      idx          <= '0;
      alloc        <= '0;
      map_done     <= 1'b0;
      covered_mask <= '0;
      fault_count  <= '0;
      unrepairable <= 1'b0;
    end else begin
      state    <= state_nxt;
      map_done <= (state == S_DONE);
      if (start_ok) begin
        snap         <= diag_mat;
        idx          <= '0;
        alloc        <= '0;
        covered_mask <= '0;
        fault_count  <= '0;
        unrepairable <= 1'b0;
      end else if (state == S_SCAN) begin
        idx <= last ? '0 : idx + 1'b1;
        if (is_fault) begin
          fault_count <= fault_count + 1'b1;
          if (can_alloc) begin
            covered_mask[idx] <= 1'b1;
            alloc             <= alloc + 1'b1;
          end else begin
            unrepairable <= 1'b1;
          end
        end
      end
    end
  end

  ru_alloc_table #(
    .NUM_RU(NUM_RU),
    .RW    (RW),
    .CW    (CW),
    .AW    (AW)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .wr_en (is_fault && can_alloc),
    .wr_ptr(alloc),
    .wr_row(RW'(coord_of(32'(idx), COLS).row)),
    .wr_col(CW'(coord_of(32'(idx), COLS).col)),
    .valid (ru_valid),
    .row   (ru_row),
    .col   (ru_col)
  );

endmodule

// File: tb/tb_ru_fault_scheduler.sv
module tb_ru_fault_scheduler;
  import bisr_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        diag_start = 1'b0;
  logic [15:0] diag_mat   = 16'hFFFF;

  // 4-RU instance
  logic       busy4, map_done4, unrep4;
  logic [3:0] valid4;
  logic [7:0] row4, col4;
  logic [15:0] cov4;
  logic [4:0] fc4;
  state_e     st4;

  // 2-RU instance, same stimulus
  logic       busy2, map_done2, unrep2;
  logic [1:0] valid2;
  logic [3:0] row2, col2;
  logic [15:0] cov2;
  logic [4:0] fc2;
  state_e     st2;

  ru_fault_scheduler #(.ROWS(4), .COLS(4), .NUM_RU(4)) u4 (
    .clk(clk), .rst(rst), .diag_start(diag_start), .diag_mat(diag_mat),
    .busy(busy4), .map_done(map_done4), .ru_valid(valid4), .ru_row(row4),
    .ru_col(col4), .covered_mask(cov4), .fault_count(fc4),
    .unrepairable(unrep4), .fsm_state(st4)
  );

  ru_fault_scheduler #(.ROWS(4), .COLS(4), .NUM_RU(2)) u2 (
    .clk(clk), .rst(rst), .diag_start(diag_start), .diag_mat(diag_mat),
    .busy(busy2), .map_done(map_done2), .ru_valid(valid2), .ru_row(row2),
    .ru_col(col2), .covered_mask(cov2), .fault_count(fc2),
    .unrepairable(unrep2), .fsm_state(st2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a scan with matrix m; after alt_at cycles of the scan, drive
  // diag_mat=alt_mat and diag_start=alt_start for one cycle. Waits (bounded)
  // for map_done and checks the start-to-done latency.
  task automatic run(input logic [15:0] m, input int alt_at,
                     input logic [15:0] alt_mat, input logic alt_start);
    int  k;
    bit  seen;
    diag_mat   = m;
    diag_start = 1'b1;
    tick();
    diag_start = 1'b0;
    chk("busy_after_start", busy4, 1);
    k    = 0;
    seen = 0;
    while (!seen && k < 40) begin
      if (k == alt_at) begin
        diag_mat   = alt_mat;
        diag_start = alt_start;
      end
      tick();
      k++;
      diag_start = 1'b0;
      if (map_done4) seen = 1;
    end
    chk("done_latency", k, 17);
    chk("done_ru2_same_cycle", map_done2, 1);
    chk("busy_at_done", busy4, 0);
  endtask

  initial begin
    int stray_done;

    // reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy4, 0);
    chk("rst_map_done", map_done4, 0);
    chk("rst_valid", valid4, 0);
    chk("rst_row", row4, 0);
    chk("rst_col", col4, 0);
    chk("rst_cov", cov4, 0);
    chk("rst_fc", fc4, 0);
    chk("rst_unrep", unrep4, 0);
    chk("rst_state", st4, S_IDLE);

    // reset mid-scan at i=7
    diag_mat   = 16'hF75E;
    diag_start = 1'b1;
    tick();
    diag_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_fc_before_rst", fc4, 2);
    chk("mid_valid_before_rst", valid4, 4'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy4, 0);
    chk("mid_rst_valid", valid4, 0);
    chk("mid_rst_cov", cov4, 0);
    chk("mid_rst_fc", fc4, 0);
    chk("mid_rst_unrep", unrep4, 0);
    chk("mid_rst_row", row4, 0);
    chk("mid_rst_col", col4, 0);
    stray_done = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (map_done4 || map_done2) stray_done++;
    end
    chk("mid_rst_no_done", stray_done, 0);

    // fault-free
    run(16'hFFFF, -1, 16'hFFFF, 1'b0);
    chk("ff_valid", valid4, 0);
    chk("ff_cov", cov4, 0);
    chk("ff_fc", fc4, 0);
    chk("ff_unrep", unrep4, 0);
    chk("ff_row", row4, 0);
    chk("ff_col", col4, 0);
    tick();
    chk("ff_done_one_cycle", map_done4, 0);

    // four faults (0,0),(1,1),(1,3),(2,3); restart at i=3 with all-faulty is ignored
    run(16'hF75E, 3, 16'h0000, 1'b1);
    chk("fit_valid", valid4, 4'hF);
    chk("fit_row", row4, 8'h94);
    chk("fit_col", col4, 8'hF4);
    chk("fit_cov", cov4, 16'h08A1);
    chk("fit_fc", fc4, 4);
    chk("fit_unrep", unrep4, 0);
    chk("ovf_valid", valid2, 2'h3);
    chk("ovf_row", row2, 4'h4);
    chk("ovf_col", col2, 4'h4);
    chk("ovf_cov", cov2, 16'h0021);
    chk("ovf_fc", fc2, 4);
    chk("ovf_unrep", unrep2, 1);
    tick(); tick(); tick();
    chk("hold_cov", cov4, 16'h08A1);
    chk("hold_fc", fc4, 4);
    chk("hold_row", row4, 8'h94);
    chk("hold_done_low", map_done4, 0);

    // single fault at index 0 clears the previous table
    run(16'hFFFE, -1, 16'hFFFE, 1'b0);
    chk("one_valid", valid4, 4'h1);
    chk("one_row", row4, 0);
    chk("one_col", col4, 0);
    chk("one_cov", cov4, 16'h0001);
    chk("one_fc", fc4, 1);
    chk("one_unrep", unrep4, 0);
    chk("one_valid_ru2", valid2, 2'h1);
    chk("one_unrep_ru2", unrep2, 0);

    // snapshot: diag_mat forced to all-faulty right after the start edge
    run(16'hFF7F, 1, 16'h0000, 1'b0);
    chk("snap_valid", valid4, 4'h1);
    chk("snap_row", row4, 8'h01);
    chk("snap_col", col4, 8'h03);
    chk("snap_cov", cov4, 16'h0080);
    chk("snap_fc", fc4, 1);
    chk("snap_unrep", unrep4, 0);

    // all sixteen PEs faulty
    run(16'h0000, -1, 16'h0000, 1'b0);
    chk("all_valid", valid4, 4'hF);
    chk("all_row", row4, 8'h00);
    chk("all_col", col4, 8'hE4);
    chk("all_cov", cov4, 16'h000F);
    chk("all_fc", fc4, 16);
    chk("all_unrep", unrep4, 1);
    chk("all_cov_ru2", cov2, 16'h0003);
    chk("all_fc_ru2", fc2, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
